// File: rtl/j2_sample_serializer.sv
// Serialises {s_1,s_0} sample pairs from the J=2 unfolded multiplier into a
// single-rate valid/ready stream (s_0 first, then s_1), buffered by a pair FIFO.
module j2_sample_serializer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             s_0,
  input  logic [WIDTH-1:0]             s_1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_phase,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  phase_t             phase;
  phase_t             phase_next;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;

  // in_ready looks only at registered state (and reset), never at out_ready,
  // so a full FIFO rejects a push even in a cycle where it pops.
  assign in_ready  = reset & (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? (phase == ODD ? head[2*WIDTH-1:WIDTH] : head[WIDTH-1:0])
                               : '0;
  assign out_phase = (phase == ODD);
  assign level     = count;

  // Pop FSM: the head entry is retired only once its s_1 half is consumed.
  always_comb begin
    phase_next = phase;
    pop        = 1'b0;
    if (out_valid && out_ready) begin
      if (phase == EVEN) begin
        phase_next = ODD;
      end else begin
        phase_next = EVEN;
        pop        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase  <= EVEN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      phase <= phase_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_1, s_0};
    end
  end

endmodule

// File: tb/tb_j2_sample_serializer.sv
// Bench for j2_sample_serializer: the model is a flat queue of expected samples
// in output order; a monitor compares every cycle against it.
module tb_j2_sample_serializer;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] s_0 = '0;
  logic [WIDTH-1:0] s_1 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_phase;
  logic [LW-1:0]    level;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int pairs;
  bit rand_mode = 1'b0;

  j2_sample_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_0       (s_0),
    .s_1       (s_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer a pair until accepted; acceptance is judged mid-cycle, after the
  // monitor has already accounted for this cycle's consumption.
  task automatic send_pair(input int a, input int b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    s_0      = WIDTH'(a);
    s_1      = WIDTH'(b);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        exp_q.push_back(a);
        exp_q.push_back(b);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
    $display("push (%0d,%0d) accepted=%0d", a, b, done);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  // Monitor: every cycle, compare DUT state with the expected-sample queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
      end else begin
        pairs = (exp_q.size() + 1) / 2;
        chk("level", int'(level), pairs);
        chk("in_ready", int'(in_ready), int'(pairs != DEPTH));
        chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          chk("out_data", int'(out_data), exp_q[0]);
          chk("out_phase", int'(out_phase), exp_q.size() % 2);
          if (out_ready) begin
            $display("pop data=%0d phase=%0d", out_data, out_phase);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // Reset held 200ns
    #2 reset = 1'b0;
    #200;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_level", int'(level), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("release_in_ready", int'(in_ready), 1);

    // Single pair
    out_ready = 1'b1;
    send_pair(15, 10);
    drain();
    chk("single_out_valid", int'(out_valid), 0);
    chk("single_level", int'(level), 0);

    // Backpressure to full, extra pair refused
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send_pair(2 * k + 1, 2 * k + 2);
    chk("full_level", int'(level), DEPTH);
    chk("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    s_0 = WIDTH'(9);
    s_1 = WIDTH'(10);
    repeat (3) tick();
    chk("full_refuse_level", int'(level), DEPTH);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Stall mid-pair
    send_pair(15, 10);
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_data", int'(out_data), 10);
      chk("stall_phase", int'(out_phase), 1);
    end
    out_ready = 1'b1;
    drain();
    chk("stall_level", int'(level), 0);

    // Full while ODD with simultaneous offer
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send_pair(100 + 2 * k, 101 + 2 * k);
    out_ready = 1'b1;
    tick();
    chk("odd_phase", int'(out_phase), 1);
    send_pair(200, 201);
    chk("simul_level", int'(level), DEPTH);

    // Random traffic well beyond 3*DEPTH pairs for pointer wrap
    rand_mode = 1'b1;
    for (int k = 0; k < 6 * DEPTH; k++) begin
      send_pair(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-stream in ODD with level 3
    out_ready = 1'b0;
    send_pair(31, 32);
    send_pair(33, 34);
    send_pair(35, 36);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_reset_phase", int'(out_phase), 1);
    chk("pre_reset_level", int'(level), 3);
    reset = 1'b0;
    exp_q.delete();
    tick();
    tick();
    chk("mid_reset_level", int'(level), 0);
    chk("mid_reset_out_valid", int'(out_valid), 0);
    reset = 1'b1;
    out_ready = 1'b1;
    send_pair(21, 0);
    chk("post_reset_first", int'(out_data), 21);
    chk("post_reset_phase", int'(out_phase), 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
